// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg
//   Shared definitions for the multi-channel ultrasonic ranging engine:
//   FSM state codes (IDLE..GAP, visible on the LED state output),
//   the microseconds-per-centimetre conversion constant, and a helper that
//   sizes the channel pointer.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TRIG = 3'd1,
    WAIT = 3'd2,
    MEAS = 3'd3,
    GAP  = 3'd4
  } state_e;

  // Round-trip echo time per centimetre of range.
  localparam int unsigned US_PER_CM = 58;

  // Width of a channel index; never less than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_mc_tick.sv
// us_tick_gen
//   Produces a one-cycle 1 us tick from the system clock by dividing by
//   CLK_HZ/1_000_000. When that ratio is 1 the tick is high every cycle.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset (clears the divider)
//   tick out 1 us strobe
module us_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (cnt_q >= CW'(DIV - 1)) cnt_d = '0;
    else                       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// ultrasonic_ranger_mc
//   Multi-channel HC-SR04 ranging engine. Channels are scanned round-robin:
//   trigger pulse, wait for echo rise, time the echo high width in 1 us ticks,
//   convert to cm (floor(us/58), saturated at DIST_MAX), then a quiet gap.
//   Results are held per channel together with a timeout flag.
// Optional build macro:
//   ULTRASONIC_AVG_EN - per-channel (prev + new + 1) >> 1 filtering of valid
//   results; the first valid sample after reset or an error is stored as-is,
//   error results leave the distance untouched.
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-high reset, aborts any measurement
//   start      in  single-cycle pulse, starts one scan (ignored when busy)
//   auto_mode  in  1 = repeat scans continuously
//   echo       in  [NUM_CH] raw asynchronous echo inputs
//   trig       out [NUM_CH] trigger outputs, at most one high
//   dist_cm    out [NUM_CH*DIST_W] latest distance, channel k at k*DIST_W
//   err        out [NUM_CH] timeout flag of the latest measurement
//   done       out one-cycle pulse on each result write
//   done_ch    out [3] channel index written at done
//   state      out [3] FSM state code
//   busy       out high whenever the FSM is not IDLE
module ultrasonic_ranger_mc
  import ultrasonic_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned GAP_US     = 60000,
  parameter int unsigned DIST_W     = 9,
  parameter int unsigned DIST_MAX   = 400
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     auto_mode,
  input  logic [NUM_CH-1:0]        echo,
  output logic [NUM_CH-1:0]        trig,
  output logic [NUM_CH*DIST_W-1:0] dist_cm,
  output logic [NUM_CH-1:0]        err,
  output logic                     done,
  output logic [2:0]               done_ch,
  output logic [2:0]               state,
  output logic                     busy
);

  localparam int unsigned CW   = ch_idx_w(NUM_CH);
  localparam int unsigned TM1  = (TRIG_US > TIMEOUT_US) ? TRIG_US : TIMEOUT_US;
  localparam int unsigned TMAX = (TM1 > GAP_US) ? TM1 : GAP_US;
  localparam int unsigned TW   = $clog2(TMAX) + 1;

  logic tick;

  us_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  state_e              state_q, state_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [5:0]          sub_q, sub_d;
  logic [DIST_W-1:0]   cm_q, cm_d;
  logic [NUM_CH-1:0]   sync1_q, sync2_q, prev_q;
  logic [NUM_CH-1:0]   trig_q, trig_d;
  logic [NUM_CH-1:0]   err_q, err_d;
  logic [DIST_W-1:0]   dist_q [NUM_CH];
  logic [DIST_W-1:0]   dist_d [NUM_CH];
  logic                done_q, done_d;
  logic [CW-1:0]       done_ch_q, done_ch_d;

  logic                echo_ch, prev_ch;
  logic                wr_en, wr_err, wr_upd;
  logic [DIST_W-1:0]   wr_val;

`ifdef ULTRASONIC_AVG_EN
  logic [NUM_CH-1:0]   valid_q, valid_d;
  logic [DIST_W:0]     avg_sum;
`endif

  assign echo_ch = sync2_q[ch_q];
  assign prev_ch = prev_q[ch_q];

  // FSM and measurement counters
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tcnt_d  = tcnt_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    wr_en   = 1'b0;
    wr_err  = 1'b0;
    wr_upd  = 1'b0;
    wr_val  = cm_q;

    case (state_q)
      IDLE: begin
        if (start || auto_mode) begin
          state_d = TRIG;
          ch_d    = '0;
          tcnt_d  = '0;
        end
      end

      TRIG: begin
        if (tick) begin
          if (tcnt_q == TW'(TRIG_US - 1)) begin
            state_d = WAIT;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      WAIT: begin
        // Edge-qualified so an echo already high on entry is not a rise.
        if (echo_ch && !prev_ch) begin
          state_d = MEAS;
          tcnt_d  = '0;
          sub_d   = '0;
          cm_d    = '0;
        end else if (tick) begin
          if (tcnt_q == TW'(TIMEOUT_US - 1)) begin
            wr_en   = 1'b1;
            wr_err  = 1'b1;
            state_d = GAP;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      MEAS: begin
        // The rise cycle is consumed by WAIT, so the fall cycle is counted
        // instead; an N-cycle echo therefore yields exactly N ticks.
        if (tick) begin
          tcnt_d = tcnt_q + 1'b1;
          if (sub_q == 6'(US_PER_CM - 1)) begin
            sub_d = '0;
            if (cm_q != DIST_W'(DIST_MAX)) cm_d = cm_q + 1'b1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
        if (!echo_ch) begin
          wr_en   = 1'b1;
          wr_upd  = 1'b1;
          wr_val  = cm_d;
          state_d = GAP;
          tcnt_d  = '0;
        end else if (tick && (tcnt_q == TW'(TIMEOUT_US - 1))) begin
          wr_en   = 1'b1;
          wr_err  = 1'b1;
`ifdef ULTRASONIC_AVG_EN
          wr_upd  = 1'b0;
`else
          wr_upd  = 1'b1;
`endif
          wr_val  = DIST_W'(DIST_MAX);
          state_d = GAP;
          tcnt_d  = '0;
        end
      end

      GAP: begin
        if (tick) begin
          if (tcnt_q == TW'(GAP_US - 1)) begin
            tcnt_d = '0;
            if (ch_q != CW'(NUM_CH - 1)) begin
              ch_d    = ch_q + 1'b1;
              state_d = TRIG;
            end else if (auto_mode) begin
              ch_d    = '0;
              state_d = TRIG;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered trigger so the pin is a clean flop output.
    trig_d = '0;
    if (state_d == TRIG) trig_d[ch_d] = 1'b1;
  end

  // Result write into the per-channel registers
  always_comb begin
    dist_d    = dist_q;
    err_d     = err_q;
    done_d    = wr_en;
    done_ch_d = done_ch_q;
`ifdef ULTRASONIC_AVG_EN
    valid_d   = valid_q;
    avg_sum   = {1'b0, dist_q[ch_q]} + {1'b0, wr_val} + 1'b1;
`endif
    if (wr_en) begin
      err_d[ch_q] = wr_err;
      done_ch_d   = ch_q;
`ifdef ULTRASONIC_AVG_EN
      valid_d[ch_q] = !wr_err;
      if (wr_upd) begin
        if (valid_q[ch_q]) dist_d[ch_q] = avg_sum[DIST_W:1];
        else               dist_d[ch_q] = wr_val;
      end
`else
      if (wr_upd) dist_d[ch_q] = wr_val;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      tcnt_q    <= '0;
      sub_q     <= '0;
      cm_q      <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      trig_q    <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) dist_q[k] <= '0;
`ifdef ULTRASONIC_AVG_EN
      valid_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      tcnt_q    <= tcnt_d;
      sub_q     <= sub_d;
      cm_q      <= cm_d;
      sync1_q   <= echo;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      trig_q    <= trig_d;
      err_q     <= err_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
      for (int unsigned k = 0; k < NUM_CH; k++) dist_q[k] <= dist_d[k];
`ifdef ULTRASONIC_AVG_EN
      valid_q   <= valid_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dist
    assign dist_cm[g*DIST_W +: DIST_W] = dist_q[g];
  end

  assign trig    = trig_q;
  assign err     = err_q;
  assign done    = done_q;
  assign done_ch = 3'(done_ch_q);
  assign state   = state_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// tb_ultrasonic_ranger_mc
//   Directed vector bench for ultrasonic_ranger_mc with a 1 MHz clock
//   (one tick per cycle), two channels and a 100 us gap.
module tb_ultrasonic_ranger_mc;

  localparam int NCH = 2;
  localparam int DW  = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              auto_mode;
  logic [NCH-1:0]    echo;
  logic [NCH-1:0]    trig;
  logic [NCH*DW-1:0] dist_cm;
  logic [NCH-1:0]    err;
  logic              done;
  logic [2:0]        done_ch;
  logic [2:0]        state;
  logic              busy;

  logic echo_drv [NCH];
  int   w_cfg    [NCH];
  bit   abort;

  int n_vec = 0;
  int n_err = 0;

  int exp_dist  [NCH];
  bit exp_valid [NCH];

  int tw_cnt   [NCH];
  bit tprev    [NCH];
  int overlap  = 0;
  int trig_order[$];

  typedef struct {
    int w0;
    int w1;
    int raw0;
    int raw1;
    bit e0;
    bit e1;
  } vec_t;

  vec_t vecs [6];

  assign echo = {echo_drv[1], echo_drv[0]};

  always #5 clk = ~clk;

  ultrasonic_ranger_mc #(
    .NUM_CH    (2),
    .CLK_HZ    (1_000_000),
    .TRIG_US   (10),
    .TIMEOUT_US(30000),
    .GAP_US    (100),
    .DIST_W    (9),
    .DIST_MAX  (400)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .auto_mode(auto_mode),
    .echo     (echo),
    .trig     (trig),
    .dist_cm  (dist_cm),
    .err      (err),
    .done     (done),
    .done_ch  (done_ch),
    .state    (state),
    .busy     (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int get_dist(input int c);
    return int'(dist_cm[c*DW +: DW]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      exp_dist[c]  = 0;
      exp_valid[c] = 1'b0;
    end
  endtask

  task automatic model_wr(input int c, input int raw, input bit e);
    if (e) begin
      exp_valid[c] = 1'b0;
    end else begin
`ifdef ULTRASONIC_AVG_EN
      if (exp_valid[c]) exp_dist[c] = (exp_dist[c] + raw + 1) >> 1;
      else              exp_dist[c] = raw;
`else
      exp_dist[c] = raw;
`endif
      exp_valid[c] = 1'b1;
    end
  endtask

  // Echo responder: after the channel's trigger falls, wait 4 cycles and
  // hold echo high for w_cfg[c] cycles (0 = sensor never answers).
  task automatic respond(input int c);
    bit tp = 1'b0;
    forever begin
      @(negedge clk);
      if (tp && !trig[c] && !rst && w_cfg[c] > 0) begin
        repeat (4) @(negedge clk);
        echo_drv[c] = 1'b1;
        for (int i = 0; i < w_cfg[c]; i++) begin
          @(negedge clk);
          if (abort) break;
        end
        echo_drv[c] = 1'b0;
      end
      tp = trig[c];
    end
  endtask

  initial respond(0);
  initial respond(1);

  // Trigger monitor: pulse width, overlap and rise order.
  always @(negedge clk) begin
    if (trig[0] && trig[1]) overlap++;
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        tw_cnt[c] = 0;
      end else if (trig[c]) begin
        if (!tprev[c]) trig_order.push_back(c);
        tw_cnt[c]++;
      end else if (tw_cnt[c] != 0) begin
        chk($sformatf("trig%0d_width", c), tw_cnt[c], 10);
        tw_cnt[c] = 0;
      end
      tprev[c] = trig[c];
    end
  end

  task automatic wait_done(output int ch, output bit ok);
    ok = 1'b0;
    ch = -1;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (done) begin
        ch = int'(done_ch);
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_idle_reached"}, int'(seen), 1);
    chk({nm, "_state_idle"}, int'(state), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int ch;
    bit ok;
    int raw [NCH];
    bit e   [NCH];
    raw[0] = v.raw0; raw[1] = v.raw1;
    e[0]   = v.e0;   e[1]   = v.e1;
    w_cfg[0] = v.w0;
    w_cfg[1] = v.w1;
    pulse_start();
    for (int k = 0; k < NCH; k++) begin
      wait_done(ch, ok);
      chk($sformatf("v%0d_done%0d_seen", idx, k), int'(ok), 1);
      chk($sformatf("v%0d_done%0d_ch", idx, k), ch, k);
      model_wr(k, raw[k], e[k]);
      chk($sformatf("v%0d_dist%0d", idx, k), get_dist(k), exp_dist[k]);
      chk($sformatf("v%0d_err%0d", idx, k), int'(err[k]), int'(e[k]));
    end
    wait_idle($sformatf("v%0d", idx));
  endtask

  initial begin
    int  ch;
    bit  ok;
    bit  seen;

    rst       = 1'b1;
    start     = 1'b0;
    auto_mode = 1'b0;
    abort     = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      echo_drv[c] = 1'b0;
      w_cfg[c]    = 0;
      tw_cnt[c]   = 0;
      tprev[c]    = 1'b0;
    end
    model_reset();

    //            w0     w1   raw0 raw1 e0 e1
    vecs[0] = '{  580,   58,  10,  1,   0, 0};
    vecs[1] = '{   57,  116,   0,  2,   0, 0};
    vecs[2] = '{24000,    1, 400,  0,   0, 0};
    vecs[3] = '{    0,   57,   0,  0,   1, 0};
    vecs[4] = '{  580,   59,  10,  1,   0, 0};
    vecs[5] = '{ 1160,  115,  20,  1,   0, 0};

    repeat (3) @(negedge clk);
    chk("rst_trig",    int'(trig),    0);
    chk("rst_dist",    int'(dist_cm), 0);
    chk("rst_err",     int'(err),     0);
    chk("rst_done",    int'(done),    0);
    chk("rst_done_ch", int'(done_ch), 0);
    chk("rst_state",   int'(state),   0);
    chk("rst_busy",    int'(busy),    0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vector(i, vecs[i]);

    // Auto scan: ch0, ch1, ch0, ch1; auto cleared during the second scan.
    trig_order.delete();
    w_cfg[0]  = 58;
    w_cfg[1]  = 116;
    auto_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(ch, ok);
      chk($sformatf("auto_done%0d_seen", k), int'(ok), 1);
      chk($sformatf("auto_done%0d_ch", k), ch, k % 2);
      model_wr(k % 2, (k % 2 == 0) ? 1 : 2, 1'b0);
      chk($sformatf("auto_dist%0d", k), get_dist(k % 2), exp_dist[k % 2]);
      if (k == 2) auto_mode = 1'b0;
    end
    wait_idle("auto");
    chk("auto_trig_count", trig_order.size(), 4);
    for (int i = 0; i < trig_order.size() && i < 4; i++)
      chk($sformatf("auto_trig_order%0d", i), trig_order[i], i % 2);

    // Reset during MEAS aborts on the next edge.
    w_cfg[0] = 24000;
    w_cfg[1] = 58;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (state == 3'd3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mrst_meas_reached", int'(seen), 1);
    repeat (100) @(negedge clk);
    rst   = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("mrst_trig",  int'(trig),    0);
    chk("mrst_state", int'(state),   0);
    chk("mrst_dist",  int'(dist_cm), 0);
    chk("mrst_err",   int'(err),     0);
    chk("mrst_busy",  int'(busy),    0);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    abort = 1'b0;
    repeat (5) @(negedge clk);
    run_vector(6, vecs[0]);

    chk("trig_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
